// File: rtl/regfile_pkg.sv
// regfile_pkg: clear FSM encoding, default sizes and slice helpers shared by the banked register file.
package regfile_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} clr_state_t;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_LANES = 2;
  localparam int DEF_NUM_RD = 2;
  function automatic int lsb(int idx, int w);
    return idx * w;
  endfunction
  function automatic logic in_range(int unsigned a, int unsigned n);
    return a < n;
  endfunction
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: walks every register once after a clear request, driving a zero-write port.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  clr_state_t state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (state == ST_IDLE) begin
      state_nxt = clr_req ? ST_CLEAR : ST_IDLE;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
      state_nxt = (cnt == AW'(NUM_REGS - 1)) ? ST_IDLE : ST_CLEAR;
    end
  end
  assign clr_busy = state == ST_CLEAR;
  assign clr_we = clr_busy;
  assign clr_addr = cnt;
endmodule

// File: rtl/banked_register_file.sv
// banked_register_file: per-lane addressed register file with registered multi-port reads, write bypass
// and a sequential clear engine; optional parity storage/checking under REGFILE_PARITY_EN.
module banked_register_file
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int LANE_W = DEF_LANE_W,
  parameter int LANES = DEF_LANES,
  parameter int NUM_RD = DEF_NUM_RD,
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clock,
  input  logic                           nreset,
  input  logic                           clr_req,
  output logic                           clr_busy,
  input  logic [LANES-1:0]               wr_en,
  input  logic [LANES*AW-1:0]            wr_addr,
  input  logic [LANES*LANE_W-1:0]        wr_data,
  input  logic [NUM_RD*LANES-1:0]        rd_en,
  input  logic [NUM_RD*LANES*AW-1:0]     rd_addr,
  output logic [NUM_RD*LANES*LANE_W-1:0] rd_data,
  output logic [NUM_RD-1:0]              rd_valid,
  output logic [NUM_RD-1:0]              par_err
);
  localparam int NRL = NUM_RD * LANES;
  logic [LANE_W-1:0] mem [NUM_REGS];
  logic clr_we;
  logic [AW-1:0] clr_addr;
  logic [LANES-1:0] we;
  logic [AW-1:0] wa [LANES];
  logic [LANE_W-1:0] wd [LANES];
  logic [NRL-1:0] re;
  logic [AW-1:0] ra [NRL];
  logic [LANE_W-1:0] rd_nxt [NRL];
  regfile_clear_seq #(.NUM_REGS(NUM_REGS), .AW(AW)) u_clr (
    .clock(clock),
    .nreset(nreset),
    .clr_req(clr_req),
    .clr_busy(clr_busy),
    .clr_we(clr_we),
    .clr_addr(clr_addr)
  );
  // Later lanes override earlier ones, so the highest-index writer is what a bypassed read sees.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      wa[k] = wr_addr[lsb(k, AW) +: AW];
      wd[k] = wr_data[lsb(k, LANE_W) +: LANE_W];
      we[k] = wr_en[k] && !clr_busy && in_range(int'(wa[k]), NUM_REGS);
    end
    for (int i = 0; i < NRL; i++) begin
      ra[i] = rd_addr[lsb(i, AW) +: AW];
      re[i] = rd_en[i] && !clr_busy && in_range(int'(ra[i]), NUM_REGS);
      rd_nxt[i] = re[i] ? mem[ra[i]] : '0;
      for (int k = 0; k < LANES; k++)
        if (re[i] && we[k] && wa[k] == ra[i]) rd_nxt[i] = wd[k];
    end
  end
  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      rd_data <= '0;
      rd_valid <= '0;
    end else begin
      for (int k = 0; k < LANES; k++)
        if (we[k]) mem[wa[k]] <= wd[k];
      if (clr_we) mem[clr_addr] <= '0;
      for (int i = 0; i < NRL; i++) rd_data[lsb(i, LANE_W) +: LANE_W] <= rd_nxt[i];
      for (int p = 0; p < NUM_RD; p++) rd_valid[p] <= !clr_busy && |rd_en[lsb(p, LANES) +: LANES];
    end
  end
`ifdef REGFILE_PARITY_EN
  logic par_mem [NUM_REGS];
  logic [NUM_RD-1:0] perr_nxt;
  logic hit;
  // Bypassed lanes carry fresh write data, so they are excluded from the stored-parity check.
  always_comb begin
    perr_nxt = '0;
    hit = 1'b0;
    for (int i = 0; i < NRL; i++) begin
      hit = 1'b0;
      for (int k = 0; k < LANES; k++) hit = hit | (we[k] && wa[k] == ra[i]);
      if (re[i] && !hit && ((^mem[ra[i]]) != par_mem[ra[i]])) perr_nxt[i / LANES] = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int r = 0; r < NUM_REGS; r++) par_mem[r] <= 1'b0;
      par_err <= '0;
    end else begin
      for (int k = 0; k < LANES; k++)
        if (we[k]) par_mem[wa[k]] <= ^wd[k];
      if (clr_we) par_mem[clr_addr] <= 1'b0;
      par_err <= perr_nxt;
    end
  end
`else
  assign par_err = '0;
`endif
endmodule

// File: tb/tb_banked_register_file.sv
// tb_banked_register_file: directed stimulus checked against an array-level model every cycle.
module tb_banked_register_file;
  localparam int N = 32;
  localparam int W = 8;
  localparam int L = 2;
  localparam int P = 2;
  localparam int AW = 5;
  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic clr_req = 1'b0;
  logic clr_busy;
  logic [L-1:0] wr_en = '0;
  logic [L*AW-1:0] wr_addr = '0;
  logic [L*W-1:0] wr_data = '0;
  logic [P*L-1:0] rd_en = '0;
  logic [P*L*AW-1:0] rd_addr = '0;
  logic [P*L*W-1:0] rd_data;
  logic [P-1:0] rd_valid, par_err;
  int n_cmp = 0;
  int n_bad = 0;
  banked_register_file dut (
    .clock(clock), .nreset(nreset), .clr_req(clr_req), .clr_busy(clr_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .par_err(par_err)
  );
  always #5 clock = ~clock;
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endfunction
  // Model: plain array of register values plus a count of clear cycles still to run.
  logic [W-1:0] model [N];
  logic [W-1:0] nxt [N];
  int clr_left = 0;
  logic [P*L*W-1:0] exp_data = '0;
  logic [P-1:0] exp_valid = '0;
  bit model_ok = 0;
  always @(posedge clock) begin
    if (!nreset) begin
      for (int r = 0; r < N; r++) model[r] = '0;
      exp_data = '0;
      exp_valid = '0;
      clr_left = 0;
      model_ok = 1;
    end else begin
      nxt = model;
      if (clr_left == 0)
        for (int k = 0; k < L; k++)
          if (wr_en[k] && int'(wr_addr[k*AW +: AW]) < N) nxt[wr_addr[k*AW +: AW]] = wr_data[k*W +: W];
      for (int i = 0; i < P*L; i++) begin
        int a;
        a = int'(rd_addr[i*AW +: AW]);
        exp_data[i*W +: W] = (clr_left == 0 && rd_en[i] && a < N) ? nxt[a] : '0;
      end
      for (int p = 0; p < P; p++) exp_valid[p] = clr_left == 0 && |rd_en[p*L +: L];
      if (clr_left > 0) begin
        nxt[N - clr_left] = '0;
        clr_left--;
      end else if (clr_req) clr_left = N;
      model = nxt;
    end
  end
  always @(negedge clock) begin
    if (model_ok) begin
      check("busy", 32'(clr_busy), 32'(clr_left > 0));
      check("valid", 32'(rd_valid), 32'(exp_valid));
      check("data", rd_data, exp_data);
`ifndef REGFILE_PARITY_EN
      check("par_err", 32'(par_err), 32'd0);
`endif
    end
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic idle;
    wr_en = '0;
    rd_en = '0;
    clr_req = 1'b0;
  endtask
  task automatic set_rd(int p, int k, int a);
    rd_addr[(p*L+k)*AW +: AW] = AW'(a);
  endtask
  task automatic read_pair(int r);
    rd_en = '1;
    set_rd(0, 0, r); set_rd(0, 1, r + 1);
    set_rd(1, 0, r + 1); set_rd(1, 1, r);
  endtask
  task automatic read_all_zero(string nm);
    for (int r = 0; r < N; r += 2) begin
      read_pair(r);
      tick;
      check(nm, rd_data, 32'h0);
    end
    idle;
  endtask
  initial begin
    int n;
    tick; tick;
    nreset = 1'b1;
    // 1: random fill, then a one-cycle reset
    for (int r = 0; r < N; r++) begin
      wr_en = 2'b01;
      wr_addr = AW'(r);
      wr_data = 16'($urandom);
      tick;
    end
    idle;
    nreset = 1'b0;
    read_pair(0);
    tick;
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_data", rd_data, 32'h0);
    nreset = 1'b1;
    read_all_zero("after_reset");
    // 2: pair write, crossed reads
    wr_en = 2'b11;
    wr_addr = {5'd17, 5'd3};
    wr_data = {8'h5A, 8'hA5};
    tick;
    idle;
    rd_en = '1;
    set_rd(0, 0, 3); set_rd(0, 1, 17); set_rd(1, 0, 17); set_rd(1, 1, 3);
    tick;
    check("pair_p0", 32'(rd_data[15:0]), 32'h5AA5);
    check("pair_p1", 32'(rd_data[31:16]), 32'hA55A);
    check("pair_valid", 32'(rd_valid), 32'd3);
    // 3: both lanes hit reg5 while port0 lane0 reads it
    wr_en = 2'b11;
    wr_addr = {5'd5, 5'd5};
    wr_data = {8'h22, 8'h11};
    rd_en = 4'b0001;
    set_rd(0, 0, 5);
    tick;
    check("bypass", 32'(rd_data[15:0]), 32'h0022);
    check("bypass_valid", 32'(rd_valid), 32'd1);
    wr_en = '0;
    tick;
    check("after_conflict", 32'(rd_data[15:0]), 32'h0022);
    // 4: fill, clear, and poke at it while busy
    for (int r = 0; r < N / 2; r++) begin
      wr_en = 2'b11;
      wr_addr = {AW'(r + 16), AW'(r)};
      wr_data = {W'(r + 8'h40), W'(r + 1)};
      tick;
    end
    wr_en = '0;
    clr_req = 1'b1;
    tick;
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      n++;
      wr_en = 2'b11;
      wr_addr = {5'd1, 5'd0};
      wr_data = 16'hFFFF;
      clr_req = 1'b1;
      read_pair(0);
      tick;
    end
    idle;
    check("busy_cycles", 32'(n), 32'd32);
    tick; tick;
    check("no_restart", 32'(clr_busy), 32'd0);
    read_all_zero("after_clear");
    // 5: reset at clear cycle 10; write in the same cycle as clr_req is taken
    wr_en = 2'b01;
    wr_addr = 5'd9;
    wr_data = 16'h0077;
    clr_req = 1'b1;
    tick;
    idle;
    repeat (9) tick;
    check("mid_busy", 32'(clr_busy), 32'd1);
    nreset = 1'b0;
    tick;
    nreset = 1'b1;
    check("reset_mid_clear", 32'(clr_busy), 32'd0);
    read_all_zero("after_mid_reset");
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    check("reclear_busy", 32'(clr_busy), 32'd1);
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    check("reclear_cycles", 32'(n), 32'd32);
`ifdef REGFILE_PARITY_EN
    // 6: corrupt one stored bit of reg7
    wr_en = 2'b11;
    wr_addr = {5'd8, 5'd7};
    wr_data = {8'h81, 8'h3C};
    tick;
    idle;
    dut.mem[7][0] = ~dut.mem[7][0];
    model[7] = model[7] ^ 8'h01;
    rd_en = 4'b0101;
    set_rd(0, 0, 7); set_rd(1, 0, 8);
    tick;
    check("par_err_hit", 32'(par_err), 32'd1);
    idle;
    tick;
    check("par_err_clear", 32'(par_err), 32'd0);
`endif
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule
